// File: rtl/w0rm_fetch_prefetch_buffer.sv
// Instruction prefetch buffer: issues single-instruction fetches against buffer credit and queues returned {inst, pc}.
// Optional macro W0RM_PREFETCH_BYPASS_EN forwards a response straight to the core when the queue is empty.
module w0rm_fetch_prefetch_buffer #(
  parameter int ADDR_WIDTH = 32,
  parameter int INST_WIDTH = 16,
  parameter int DEPTH      = 4,
  parameter int ADDR_STEP  = 2,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic                  mem_valid_o,
  input  logic [INST_WIDTH-1:0] mem_data_i,
  input  logic                  mem_valid_i,
  input  logic                  redirect_i,
  input  logic [ADDR_WIDTH-1:0] redirect_pc_i,
  output logic [INST_WIDTH-1:0] inst_data_o,
  output logic [ADDR_WIDTH-1:0] inst_pc_o,
  output logic                  inst_valid_o,
  input  logic                  inst_ready_i
);

  // Handshake: the core takes the head entry on any cycle where inst_valid_o && inst_ready_i;
  // the memory side has no backpressure, so every mem_valid_i is consumed in its cycle.

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW+1:0] DEPTH_C = (CW+2)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] STEP_C = ADDR_WIDTH'(ADDR_STEP);

  logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_WIDTH-1:0] resp_pc_q, resp_pc_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic                  mem_valid_q, mem_valid_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [CW-1:0]         outstanding_q, outstanding_d;
  logic [CW-1:0]         discard_q, discard_d;

  logic [INST_WIDTH-1:0] fifo_data_q [DEPTH];
  logic [ADDR_WIDTH-1:0] fifo_pc_q   [DEPTH];

  logic                  resp_live;
  logic                  bypass_take;
  logic                  push;
  logic                  pop;
  logic                  issue;
  logic                  fifo_nonempty;
  logic [CW+1:0]         credit_used;

  assign mem_addr_o    = mem_addr_q;
  assign mem_valid_o   = mem_valid_q;
  assign fifo_nonempty = (count_q != '0);

  always_comb begin
    resp_live = mem_valid_i && !redirect_i && (discard_q == '0);
`ifdef W0RM_PREFETCH_BYPASS_EN
    // The response is shown directly only when nothing older is waiting ahead of it.
    inst_valid_o = fifo_nonempty || resp_live;
    inst_data_o  = fifo_nonempty ? fifo_data_q[rd_ptr_q] : (resp_live ? mem_data_i : '0);
    inst_pc_o    = fifo_nonempty ? fifo_pc_q[rd_ptr_q]   : (resp_live ? resp_pc_q  : '0);
    bypass_take  = resp_live && !fifo_nonempty && inst_ready_i;
`else
    inst_valid_o = fifo_nonempty;
    inst_data_o  = fifo_nonempty ? fifo_data_q[rd_ptr_q] : '0;
    inst_pc_o    = fifo_nonempty ? fifo_pc_q[rd_ptr_q]   : '0;
    bypass_take  = 1'b0;
`endif
    push = resp_live && !bypass_take;
    pop  = fifo_nonempty && inst_ready_i && !redirect_i;
  end

  always_comb begin
    // Discarded requests still hold credit until their stale responses drain.
    credit_used = {2'b00, count_q} + {2'b00, outstanding_q} + {2'b00, discard_q};
    issue       = !redirect_i && (credit_used < DEPTH_C);

    mem_valid_d   = issue;
    mem_addr_d    = issue ? fetch_pc_q : mem_addr_q;
    fetch_pc_d    = fetch_pc_q;
    resp_pc_d     = resp_pc_q;
    outstanding_d = outstanding_q;
    discard_d     = discard_q;
    count_d       = count_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;

    if (redirect_i) begin
      fetch_pc_d    = redirect_pc_i;
      resp_pc_d     = redirect_pc_i;
      outstanding_d = '0;
      discard_d     = outstanding_q + discard_q - CW'(mem_valid_i);
      count_d       = '0;
      rd_ptr_d      = '0;
      wr_ptr_d      = '0;
    end else begin
      if (issue) fetch_pc_d = fetch_pc_q + STEP_C;
      if (resp_live) resp_pc_d = resp_pc_q + STEP_C;
      outstanding_d = outstanding_q + CW'(issue) - CW'(resp_live);
      if (mem_valid_i && (discard_q != '0)) discard_d = discard_q - CW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q    <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      mem_addr_q    <= RESET_PC;
      mem_valid_q   <= 1'b0;
      outstanding_q <= '0;
      discard_q     <= '0;
      count_q       <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      mem_addr_q    <= mem_addr_d;
      mem_valid_q   <= mem_valid_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      count_q       <= count_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
    end
  end

  // Storage needs no reset: entries are only observable once count_q covers them.
  always_ff @(posedge clk) begin
    if (push && !reset) begin
      fifo_data_q[wr_ptr_q] <= mem_data_i;
      fifo_pc_q[wr_ptr_q]   <= resp_pc_q;
    end
  end

endmodule

// File: tb/tb_w0rm_fetch_prefetch_buffer.sv
// Bench for w0rm_fetch_prefetch_buffer: in-order memory model with per-request epochs and an expected-entry queue.
module tb_w0rm_fetch_prefetch_buffer;
  localparam int AW = 32;
  localparam int IW = 16;
  localparam int DEPTH = 4;
  localparam int STEP = 2;
  localparam logic [AW-1:0] RPC = 32'h0;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [AW-1:0] mem_addr_o;
  logic          mem_valid_o;
  logic [IW-1:0] mem_data_i = '0;
  logic          mem_valid_i = 1'b0;
  logic          redirect_i = 1'b0;
  logic [AW-1:0] redirect_pc_i = '0;
  logic [IW-1:0] inst_data_o;
  logic [AW-1:0] inst_pc_o;
  logic          inst_valid_o;
  logic          inst_ready_i = 1'b0;

  w0rm_fetch_prefetch_buffer #(
    .ADDR_WIDTH(AW), .INST_WIDTH(IW), .DEPTH(DEPTH), .ADDR_STEP(STEP), .RESET_PC(RPC)
  ) dut (
    .clk(clk), .reset(reset),
    .mem_addr_o(mem_addr_o), .mem_valid_o(mem_valid_o),
    .mem_data_i(mem_data_i), .mem_valid_i(mem_valid_i),
    .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .inst_data_o(inst_data_o), .inst_pc_o(inst_pc_o),
    .inst_valid_o(inst_valid_o), .inst_ready_i(inst_ready_i)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int lat = 1;
  int epoch = 0;
  int req_count = 0;
  int acc_count = 0;
  bit redir_prev = 1'b0;
  bit redir_on_resp = 1'b0;
  int full_thresh = 0;
  bit fired = 1'b0;

  logic [AW-1:0]      pq_addr[$];
  int                 pq_due[$];
  int                 pq_ep[$];
  logic [IW+AW-1:0]   exp_q[$];
  logic [AW-1:0]      acc_pcs[$];
  logic [AW-1:0]      exp_req_pc = RPC;

  function automatic logic [IW-1:0] img(input logic [AW-1:0] a);
    return (a[15:0] * 16'd7) ^ a[31:16] ^ 16'h3C5A;
  endfunction

  // One clock cycle: memory model, input drive, scoreboard compare, model update.
  task automatic cycle(input bit do_redir, input logic [AW-1:0] rpc, input bit rdy);
    bit resp;
    bit live;
    bit redir;
    logic [IW+AW-1:0] e;
    @(negedge clk);
    cyc++;
    if (reset) begin
      pq_addr.delete(); pq_due.delete(); pq_ep.delete();
      exp_q.delete(); acc_pcs.delete();
      exp_req_pc = RPC;
      epoch++;
      mem_valid_i = 1'b0;
      redirect_i = 1'b0;
      inst_ready_i = rdy;
      redir_prev = 1'b0;
    end else begin
      if (mem_valid_o) begin
        checks++;
        if (redir_prev) begin
          errors++;
          $display("FAIL req_after_redirect got mem_valid_o=1 exp 0 cycle %0d", cyc);
        end
        checks++;
        if (mem_addr_o !== exp_req_pc) begin
          errors++;
          $display("FAIL mem_addr got %h exp %h cycle %0d", mem_addr_o, exp_req_pc, cyc);
        end
        pq_addr.push_back(mem_addr_o);
        pq_due.push_back(cyc + lat);
        pq_ep.push_back(epoch);
        exp_req_pc = exp_req_pc + AW'(STEP);
        req_count++;
      end
      resp = (pq_addr.size() > 0) && (pq_due[0] <= cyc);
      redir = do_redir || (redir_on_resp && resp && (exp_q.size() >= full_thresh));
      if (redir && !do_redir) fired = 1'b1;
      live = 1'b0;
      e = '0;
      if (resp) begin
        live = !redir && (pq_ep[0] == epoch);
        e = {img(pq_addr[0]), pq_addr[0]};
        mem_data_i = img(pq_addr[0]);
        void'(pq_addr.pop_front()); void'(pq_due.pop_front()); void'(pq_ep.pop_front());
      end else begin
        mem_data_i = IW'($urandom);
      end
      mem_valid_i = resp;
      redirect_i = redir;
      redirect_pc_i = rpc;
      inst_ready_i = rdy;
`ifdef W0RM_PREFETCH_BYPASS_EN
      if (live) exp_q.push_back(e);
`endif
      #1;
      checks++;
      if (inst_valid_o !== (exp_q.size() != 0)) begin
        errors++;
        $display("FAIL inst_valid got %b exp %b cycle %0d", inst_valid_o, exp_q.size() != 0, cyc);
      end
      if (exp_q.size() != 0) begin
        checks++;
        if ({inst_data_o, inst_pc_o} !== exp_q[0]) begin
          errors++;
          $display("FAIL head_entry got %h/%h exp %h/%h cycle %0d", inst_data_o, inst_pc_o,
                   exp_q[0][IW+AW-1:AW], exp_q[0][AW-1:0], cyc);
        end
      end
      checks++;
      if (pq_addr.size() + exp_q.size() > DEPTH) begin
        errors++;
        $display("FAIL credit got %0d exp <= %0d cycle %0d", pq_addr.size() + exp_q.size(), DEPTH, cyc);
      end
      if (inst_valid_o && rdy && !redir) begin
        acc_pcs.push_back(inst_pc_o);
        acc_count++;
        if (exp_q.size() != 0) void'(exp_q.pop_front());
      end
`ifndef W0RM_PREFETCH_BYPASS_EN
      if (live) exp_q.push_back(e);
`endif
      if (redir) begin
        exp_q.delete();
        acc_pcs.delete();
        exp_req_pc = rpc;
        epoch++;
      end
      redir_prev = redir;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) cycle(1'b0, '0, 1'b0);
    #1;
    checks++;
    if ({mem_valid_o, inst_valid_o} !== 2'b00) begin
      errors++;
      $display("FAIL reset_valids got %b exp 00", {mem_valid_o, inst_valid_o});
    end
    checks++;
    if (mem_addr_o !== RPC) begin
      errors++;
      $display("FAIL reset_mem_addr got %h exp %h", mem_addr_o, RPC);
    end
    checks++;
    if ({inst_data_o, inst_pc_o} !== '0) begin
      errors++;
      $display("FAIL reset_head got %h/%h exp 0/0", inst_data_o, inst_pc_o);
    end
    reset = 1'b0;
    req_count = 0;
    acc_count = 0;
  endtask

  task automatic test_stream;
    lat = 1;
    for (int i = 0; i < 20; i++) cycle(1'b0, '0, 1'b1);
    checks++;
    if (acc_count != 18) begin
      errors++;
      $display("FAIL stream_throughput got %0d exp 18", acc_count);
    end
  endtask

  task automatic test_backpressure;
    test_reset();
    lat = 1;
    for (int i = 0; i < 12; i++) cycle(1'b0, '0, 1'b0);
    checks++;
    if (req_count != 4) begin
      errors++;
      $display("FAIL hold_requests got %0d exp 4", req_count);
    end
    for (int i = 0; i < 8; i++) cycle(1'b0, '0, 1'b1);
    checks++;
    if (acc_pcs.size() < 5 || acc_pcs[4] !== 32'h8) begin
      errors++;
      $display("FAIL hold_release got %0d entries exp pc 8 at index 4", acc_pcs.size());
    end
  endtask

  task automatic test_redirect_inflight;
    int n;
    test_reset();
    lat = 3;
    n = 0;
    while (pq_addr.size() != 2 && n < 20) begin
      cycle(1'b0, '0, 1'b1);
      n++;
    end
    checks++;
    if (pq_addr.size() != 2) begin
      errors++;
      $display("FAIL inflight_setup got %0d exp 2", pq_addr.size());
    end
    cycle(1'b1, 32'h100, 1'b1);
    for (int i = 0; i < 12; i++) cycle(1'b0, '0, 1'b1);
    checks++;
    if (acc_pcs.size() == 0 || acc_pcs[0] !== 32'h100) begin
      errors++;
      $display("FAIL redirect_first_pc got %0d entries exp pc 100 first", acc_pcs.size());
    end
  endtask

  task automatic test_redirect_full;
    int n;
    test_reset();
    lat = 2;
    redir_on_resp = 1'b1;
    full_thresh = DEPTH - 1;
    fired = 1'b0;
    n = 0;
    while (!fired && n < 30) begin
      cycle(1'b0, 32'h200, 1'b0);
      n++;
    end
    redir_on_resp = 1'b0;
    full_thresh = 0;
    checks++;
    if (!fired) begin
      errors++;
      $display("FAIL redirect_full_trigger got 0 exp 1");
    end
    cycle(1'b0, '0, 1'b0);
    checks++;
    if (inst_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL flush_valid got %b exp 0", inst_valid_o);
    end
    for (int i = 0; i < 10; i++) cycle(1'b0, '0, 1'b1);
    checks++;
    if (acc_pcs.size() == 0 || acc_pcs[0] !== 32'h200) begin
      errors++;
      $display("FAIL redirect_full_pc got %0d entries exp pc 200 first", acc_pcs.size());
    end
  endtask

  task automatic test_wrap;
    lat = 1;
    cycle(1'b1, 32'hFFFF_FFFC, 1'b1);
    for (int i = 0; i < 10; i++) cycle(1'b0, '0, 1'b1);
    checks++;
    if (acc_pcs.size() < 3 || acc_pcs[0] !== 32'hFFFF_FFFC || acc_pcs[1] !== 32'hFFFF_FFFE ||
        acc_pcs[2] !== 32'h0) begin
      errors++;
      $display("FAIL pc_wrap got %0d entries exp FFFFFFFC,FFFFFFFE,0", acc_pcs.size());
    end
  endtask

  task automatic test_random;
    logic [AW-1:0] rpc;
    for (int i = 0; i < 400; i++) begin
      if (i % 40 == 0) lat = $urandom_range(1, 4);
      redir_on_resp = ($urandom_range(0, 30) == 0);
      rpc = $urandom;
      rpc[0] = 1'b0;
      cycle(($urandom_range(0, 24) == 0), rpc, ($urandom_range(0, 3) != 0));
    end
    redir_on_resp = 1'b0;
  endtask

  task automatic test_midreset;
    lat = 2;
    for (int i = 0; i < 15; i++) cycle(1'b0, '0, ($urandom_range(0, 1) == 1));
    test_reset();
    lat = 1;
    for (int i = 0; i < 10; i++) cycle(1'b0, '0, 1'b1);
    checks++;
    if (acc_pcs.size() == 0 || acc_pcs[0] !== RPC) begin
      errors++;
      $display("FAIL midreset_restart got %0d entries exp pc %h first", acc_pcs.size(), RPC);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_inflight();
    test_redirect_full();
    test_wrap();
    test_random();
    test_midreset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
